// File: rtl/nand2_char_pkg.sv
// Shared types and constants for the NAND2 characterization sequencer.
// Holds the FSM state encoding and the Gray-ordered stimulus table.
// The table order changes only one cell input per vector step.
package nand2_char_pkg;

  localparam int NUM_VEC = 4;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    NEXT,
    FINISH
  } state_e;

  // One stimulus vector: cell drive levels plus the expected NAND output
  typedef struct packed {
    logic a;
    logic b;
    logic y;
  } vec_t;

  localparam vec_t VEC0 = '{a: 1'b0, b: 1'b0, y: 1'b1};
  localparam vec_t VEC1 = '{a: 1'b0, b: 1'b1, y: 1'b1};
  localparam vec_t VEC2 = '{a: 1'b1, b: 1'b1, y: 1'b0};
  localparam vec_t VEC3 = '{a: 1'b1, b: 1'b0, y: 1'b1};

  // Index 0 is the least significant entry
  localparam vec_t [NUM_VEC-1:0] VEC_TABLE = {VEC3, VEC2, VEC1, VEC0};

endpackage

// File: rtl/settle_detector.sv
// Times how long y_dig takes to settle to the expected value for one vector.
// Flags settle after STABLE_CYCLES consecutive matches, or timeout at TIMEOUT cycles.
// settled/timed_out/latency are combinational views of this cycle's sample.
module settle_detector #(
  parameter int STABLE_CYCLES = 3,
  parameter int TIMEOUT       = 255,
  parameter int CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             y_dig_i,
  input  logic             expected_i,
  output logic             settled_o,
  output logic             timed_out_o,
  output logic [CNT_W-1:0] latency_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] stable_q, stable_d;

  // Next counts: delay saturates at TIMEOUT, stable restarts on any mismatch
  always_comb begin
    delay_d  = delay_q;
    stable_d = stable_q;
    if (en_i) begin
      if (delay_q != TIMEOUT_C) begin
        delay_d = delay_q + ONE_C;
      end
      if (y_dig_i == expected_i) begin
        if (stable_q != STABLE_C) begin
          stable_d = stable_q + ONE_C;
        end
      end else begin
        stable_d = '0;
      end
    end
  end

  assign settled_o   = en_i && (stable_d == STABLE_C);
  assign timed_out_o = en_i && (delay_d == TIMEOUT_C);
  // Latency is the WAIT cycle of the first sample in the matching run
  assign latency_o   = delay_d - STABLE_C + ONE_C;

  // Counter state, zeroed when a new vector is applied
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      delay_q  <= '0;
      stable_q <= '0;
    end else begin
      delay_q  <= delay_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/nand2_char_seq.sv
// Sweeps a NAND2 cell through four Gray-ordered vectors and records settle results.
// Sweep takes 4*(latency+STABLE_CYCLES+1)+1 cycles from start to done when all pass.
// start is ignored while busy; no downstream backpressure, results held until next start.
module nand2_char_seq
  import nand2_char_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int TIMEOUT       = 255,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_dig,
  output logic             A_drv,
  output logic             B_drv,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_mask,
  output logic [CNT_W-1:0] max_delay,
  output logic [1:0]       vec_idx
);

  state_e           state_q;
  logic             a_drv_q, b_drv_q;
  logic             busy_q, done_q, pass_q;
  logic [3:0]       fail_mask_q;
  logic [CNT_W-1:0] max_delay_q;
  logic [1:0]       vec_idx_q;

  logic             settled, timed_out;
  logic [CNT_W-1:0] latency;
  logic             expected;

  assign expected = VEC_TABLE[vec_idx_q].y;

  settle_detector #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .TIMEOUT      (TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_settle (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (state_q == APPLY),
    .en_i       (state_q == WAIT),
    .y_dig_i    (y_dig),
    .expected_i (expected),
    .settled_o  (settled),
    .timed_out_o(timed_out),
    .latency_o  (latency)
  );

  // Sweep FSM with all outputs registered; done is raised on entry to FINISH
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_drv_q     <= 1'b0;
      b_drv_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      max_delay_q <= '0;
      vec_idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            fail_mask_q <= '0;
            max_delay_q <= '0;
            pass_q      <= 1'b0;
            vec_idx_q   <= '0;
            busy_q      <= 1'b1;
            state_q     <= APPLY;
          end
        end
        APPLY: begin
          a_drv_q <= VEC_TABLE[vec_idx_q].a;
          b_drv_q <= VEC_TABLE[vec_idx_q].b;
          state_q <= WAIT;
        end
        WAIT: begin
          // A settle on the timeout cycle still counts as a pass
          if (settled) begin
            if (latency > max_delay_q) begin
              max_delay_q <= latency;
            end
            state_q <= NEXT;
          end else if (timed_out) begin
            fail_mask_q[vec_idx_q] <= 1'b1;
            state_q                <= NEXT;
          end
        end
        NEXT: begin
          if (vec_idx_q == 2'(NUM_VEC - 1)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (fail_mask_q == 4'b0000);
            state_q <= FINISH;
          end else begin
            vec_idx_q <= vec_idx_q + 2'd1;
            state_q   <= APPLY;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign A_drv     = a_drv_q;
  assign B_drv     = b_drv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign max_delay = max_delay_q;
  assign vec_idx   = vec_idx_q;

endmodule
